// File: rtl/spu32_cpu_fetch.sv
// spu32_cpu_fetch: sequential word prefetch into a small FIFO, flushed on redirect.
// Define SPU32_FETCH_MISALIGN_EN to halt fetch on a misaligned redirect target.
`ifndef BUSOP_READW
`define BUSOP_READW 3'b010
`endif

module spu32_cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc,
  input  logic        I_take,
  output logic        O_valid,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic        O_bus_stb,
  output logic [31:0] O_bus_addr,
  output logic [2:0]  O_busop,
  input  logic        I_bus_ack,
  input  logic [31:0] I_bus_data,
  output logic        O_misaligned
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          stb_q, stb_d;
  logic          stale_q, stale_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pcbuf_q [DEPTH];

  logic          push;
  logic          pop;
  logic          mis;
  logic          redir_mis;
  logic [31:0]   redir_pc;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign O_valid    = (cnt_q != '0);
  assign O_instr    = instr_q[rd_q];
  assign O_bus_stb  = stb_q;
  assign O_bus_addr = addr_q;
  assign O_busop    = `BUSOP_READW;

`ifdef SPU32_FETCH_MISALIGN_EN
  logic        mis_q;
  logic [31:0] trap_q;

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      mis_q  <= 1'b0;
      trap_q <= 32'h0;
    end else if (I_redirect) begin
      mis_q  <= redir_mis;
      trap_q <= I_redirect_pc;
    end
  end

  assign mis          = mis_q;
  assign redir_pc     = I_redirect_pc;
  assign redir_mis    = |I_redirect_pc[1:0];
  assign O_misaligned = mis_q;
  assign O_pc         = mis_q ? trap_q : pcbuf_q[rd_q];
`else
  logic unused_lo;

  assign unused_lo    = ^I_redirect_pc[1:0];
  assign mis          = 1'b0;
  assign redir_pc     = {I_redirect_pc[31:2], 2'b00};
  assign redir_mis    = 1'b0;
  assign O_misaligned = 1'b0;
  assign O_pc         = pcbuf_q[rd_q];
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    stb_d      = stb_q;
    stale_d    = stale_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (I_redirect) begin
      fetch_pc_d = redir_pc;
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
      // an in-flight read must finish on the bus; its data is discarded
      if (stb_q && !I_bus_ack) begin
        stale_d = 1'b1;
      end else if (stb_q) begin
        stb_d   = 1'b0;
        stale_d = 1'b0;
      end else if (!redir_mis) begin
        stb_d  = 1'b1;
        addr_d = {redir_pc[31:2], 2'b00};
      end
    end else begin
      if (stb_q && I_bus_ack) begin
        stb_d   = 1'b0;
        stale_d = 1'b0;
        if (!stale_q) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end else if (!stb_q && !mis && (cnt_q < CW'(DEPTH))) begin
        stb_d  = 1'b1;
        addr_d = {fetch_pc_q[31:2], 2'b00};
      end
      pop = I_take && O_valid;
      if (push) begin
        wr_d = ptr_inc(wr_q);
      end
      if (pop) begin
        rd_d = ptr_inc(rd_q);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= 32'h0;
      stb_q      <= 1'b0;
      stale_q    <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 32'h0;
        pcbuf_q[i] <= 32'h0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      stb_q      <= stb_d;
      stale_q    <= stale_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      if (push) begin
        instr_q[wr_q] <= I_bus_data;
        pcbuf_q[wr_q] <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_spu32_cpu_fetch.sv
// tb_spu32_cpu_fetch: directed fetch scenarios with a bus responder and a
// scoreboard of expected pops checked by a negedge monitor.
module tb_spu32_cpu_fetch;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        I_reset;
  logic        I_redirect;
  logic [31:0] I_redirect_pc;
  logic        I_take;
  logic        O_valid;
  logic [31:0] O_instr;
  logic [31:0] O_pc;
  logic        O_bus_stb;
  logic [31:0] O_bus_addr;
  logic [2:0]  O_busop;
  logic        I_bus_ack;
  logic [31:0] I_bus_data;
  logic        O_misaligned;

  always #5 clk = ~clk;

  spu32_cpu_fetch #(
    .RESET_PC(32'h0000_0100),
    .DEPTH   (2)
  ) dut (
    .I_clk        (clk),
    .I_reset      (I_reset),
    .I_redirect   (I_redirect),
    .I_redirect_pc(I_redirect_pc),
    .I_take       (I_take),
    .O_valid      (O_valid),
    .O_instr      (O_instr),
    .O_pc         (O_pc),
    .O_bus_stb    (O_bus_stb),
    .O_bus_addr   (O_bus_addr),
    .O_busop      (O_busop),
    .I_bus_ack    (I_bus_ack),
    .I_bus_data   (I_bus_data),
    .O_misaligned (O_misaligned)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] expq [$];
  logic [31:0] issued [$];
  bit          hold_ack = 1'b0;
  bit          manual = 1'b0;
  bit          take_en = 1'b0;
  int          lat = 1;
  int          bus_cnt = 0;
  logic        prev_stb = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] mon_e;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] first_issue(input int idx);
    if (issued.size() > idx) return issued[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    I_take = take_en && (expq.size() > 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    take_en = 1'b1;
    while (expq.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    take_en = 1'b0;
    I_take  = 1'b0;
    check({name, "_drain_left"}, 32'(expq.size()), 32'h0);
    expq.delete();
  endtask

  task automatic redirect(input logic [31:0] pc);
    I_redirect    = 1'b1;
    I_redirect_pc = pc;
    tick();
    I_redirect    = 1'b0;
  endtask

  task automatic wait_issue(input string name, input logic [31:0] pc);
    int n = 0;
    while (!(O_bus_stb && O_bus_addr == pc) && n < 50) begin
      tick();
      n++;
    end
    check({name, "_issue_seen"}, {31'b0, O_bus_stb}, 32'h1);
  endtask

  // bus responder: acks after lat cycles of a visible strobe
  initial begin
    I_bus_ack  = 1'b0;
    I_bus_data = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!manual) begin
        I_bus_ack = 1'b0;
        if (O_bus_stb && !I_reset && !hold_ack) begin
          bus_cnt++;
          if (bus_cnt >= lat) begin
            I_bus_ack  = 1'b1;
            I_bus_data = O_bus_addr ^ K;
            bus_cnt    = 0;
          end
        end else if (!O_bus_stb) begin
          bus_cnt = 0;
        end
      end
    end
  end

  // monitor: issue log, bus protocol checks and scoreboard pops
  always @(negedge clk) begin
    if (!I_reset) begin
      if (O_bus_stb && !prev_stb) begin
        issued.push_back(O_bus_addr);
        check("issue_align", {30'b0, O_bus_addr[1:0]}, 32'h0);
      end
      if (prev_stb && !prev_ack && O_bus_stb) begin
        check("addr_stable", O_bus_addr, prev_addr);
      end
      if (prev_stb && prev_ack) begin
        check("stb_drop_after_ack", {31'b0, O_bus_stb}, 32'h0);
      end
      if (O_valid && I_take && !I_redirect) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pop: got pc %h expected none", O_pc);
        end else begin
          mon_e = expq.pop_front();
          check("pop_pc", O_pc, mon_e);
          check("pop_instr", O_instr, mon_e ^ K);
        end
      end
    end
    prev_stb  = O_bus_stb && !I_reset;
    prev_ack  = I_bus_ack;
    prev_addr = O_bus_addr;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    I_reset       = 1'b1;
    I_redirect    = 1'b0;
    I_redirect_pc = 32'h0;
    I_take        = 1'b0;
    repeat (3) tick();
    check("rst_valid", {31'b0, O_valid}, 32'h0);
    check("rst_stb", {31'b0, O_bus_stb}, 32'h0);
    check("rst_mis", {31'b0, O_misaligned}, 32'h0);
    check("rst_instr", O_instr, 32'h0);
    check("rst_pc", O_pc, 32'h0);
    check("busop", {29'b0, O_busop}, 32'h2);

    // 1: fill to DEPTH with single-cycle acks, no takes
    I_reset = 1'b0;
    lat     = 1;
    repeat (12) tick();
    check("t1_issue_cnt", 32'(issued.size()), 32'h2);
    check("t1_issue0", first_issue(0), 32'h100);
    check("t1_issue1", first_issue(1), 32'h104);
    check("t1_stb_full", {31'b0, O_bus_stb}, 32'h0);
    check("t1_valid", {31'b0, O_valid}, 32'h1);
    check("t1_pc", O_pc, 32'h100);
    check("t1_instr", O_instr, 32'hA5A5_A4A5);

    // 2: 3-cycle bus, continuous takes
    lat = 3;
    for (int i = 0; i < 5; i++) expq.push_back(32'h100 + 32'(4 * i));
    drain("t2");

    // 3: redirect while the read of 0x108 is outstanding
    redirect(32'h108);
    wait_issue("t3_setup", 32'h108);
    hold_ack = 1'b1;
    redirect(32'h2000);
    issued.delete();
    check("t3_valid_flush", {31'b0, O_valid}, 32'h0);
    check("t3_stb_held", {31'b0, O_bus_stb}, 32'h1);
    check("t3_addr_held", O_bus_addr, 32'h108);
    lat      = 2;
    hold_ack = 1'b0;
    expq.push_back(32'h2000);
    expq.push_back(32'h2004);
    drain("t3");
    check("t3_first_issue", first_issue(0), 32'h2000);

    // 4: redirect, take and ack in the same cycle
    lat = 1;
    n = 0;
    while (n < 3) begin
      tick();
      n = O_bus_stb ? 0 : n + 1;
    end
    manual    = 1'b1;
    I_bus_ack = 1'b0;
    redirect(32'h3000);
    check("t4_stb", {31'b0, O_bus_stb}, 32'h1);
    check("t4_addr", O_bus_addr, 32'h3000);
    I_bus_ack  = 1'b1;
    I_bus_data = 32'h3000 ^ K;
    tick();
    I_bus_ack = 1'b0;
    tick();
    check("t4_valid_pre", {31'b0, O_valid}, 32'h1);
    check("t4_stb_pre", {31'b0, O_bus_stb}, 32'h1);
    I_take     = 1'b1;
    I_bus_ack  = 1'b1;
    I_bus_data = 32'hDEAD_BEEF;
    redirect(32'h4000);
    I_bus_ack = 1'b0;
    issued.delete();
    check("t4_valid_flush", {31'b0, O_valid}, 32'h0);
    manual = 1'b0;
    expq.push_back(32'h4000);
    expq.push_back(32'h4004);
    drain("t4");
    check("t4_first_issue", first_issue(0), 32'h4000);

    // 5: PC wraps past 0xFFFFFFFC
    redirect(32'hFFFF_FFFC);
    issued.delete();
    expq.push_back(32'hFFFF_FFFC);
    expq.push_back(32'h0);
    expq.push_back(32'h4);
    drain("t5");
    check("t5_issue0", first_issue(0), 32'hFFFF_FFFC);
    check("t5_issue1", first_issue(1), 32'h0);

    // 6: misaligned redirect target
    redirect(32'h2002);
    issued.delete();
`ifdef SPU32_FETCH_MISALIGN_EN
    repeat (8) tick();
    check("t6_mis_set", {31'b0, O_misaligned}, 32'h1);
    check("t6_trap_pc", O_pc, 32'h2002);
    check("t6_valid", {31'b0, O_valid}, 32'h0);
    check("t6_no_issue", 32'(issued.size()), 32'h0);
    check("t6_stb", {31'b0, O_bus_stb}, 32'h0);
    redirect(32'h3000);
    check("t6_mis_clr", {31'b0, O_misaligned}, 32'h0);
    expq.push_back(32'h3000);
    drain("t6");
    check("t6_first_issue", first_issue(0), 32'h3000);
`else
    check("t6_mis_tied", {31'b0, O_misaligned}, 32'h0);
    expq.push_back(32'h2000);
    drain("t6");
    check("t6_first_issue", first_issue(0), 32'h2000);
`endif

    // reset mid-transaction drops the strobe at once
    redirect(32'h500);
    wait_issue("t7_setup", 32'h500);
    hold_ack = 1'b1;
    I_reset  = 1'b1;
    tick();
    check("t7_rst_stb", {31'b0, O_bus_stb}, 32'h0);
    check("t7_rst_valid", {31'b0, O_valid}, 32'h0);
    I_reset  = 1'b0;
    hold_ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
